inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  byte address of requested word (= pc).
REQ-006 imem_ready  input  1  memory accepts request; imem_rdata valid same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  decode/downstream cannot accept a new instruction.
REQ-009 jump  input  1  current instruction is a jump (from decoder).
REQ-010 jump_immediate  input  26  jump target field (from decoder).
REQ-011 branch_taken  input  1  current instruction is a taken beq (from execute).
REQ-012 branch_offset  input  16  beq immediate, word offset, signed.
REQ-013 halt  input  1  current instruction is halt (decoder noop).
REQ-014 instruction  output  32  registered instruction word to decoder.
REQ-015 inst_valid  output  1  instruction holds a live instruction.
REQ-016 pc_out  output  32  address of instruction currently presented.
REQ-017 pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-018 halted  output  1  fetch permanently stopped until reset.

Function
REQ-019 FSM SHALL have states FETCH, STALLED, HALTED.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1 and no redirect, instruction<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4 (1-cycle latency request-to-output).
REQ-021 FETCH with imem_ready=0: pc, instruction, inst_valid unchanged; request held.
REQ-022 stall=1 in FETCH -> STALLED; STALLED: imem_req=0, all registers held; stall=0 -> FETCH.
REQ-023 Redirect inputs (halt, jump, branch_taken) SHALL be acted on only when inst_valid=1 and stall=0; otherwise ignored.
REQ-024 Redirect priority: halt > jump > branch_taken > sequential.
REQ-025 Jump target = {pc_plus4[31:28], jump_immediate, 2'b00}.
REQ-026 Branch target = pc_plus4 + (sign-extended branch_offset << 2), 32-bit wrap-around.
REQ-027 On jump/branch: pc<=target, inst_valid<=0 next cycle; any imem_rdata accepted that cycle SHALL be discarded.
REQ-028 On halt: -> HALTED; imem_req=0, inst_valid<=0, halted=1; exit only via rst.
REQ-029 Redirect coincident with stall=1 SHALL be deferred until stall=0 (inputs re-sampled then).
REQ-030 pc+4 at 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-031 imem_addr SHALL be word-aligned at all times.

Reset
REQ-032 rst=1: pc=RESET_PC, state=FETCH, instruction=32'h0, inst_valid=0, pc_out=RESET_PC, halted=0, imem_req=0 during reset cycle.
REQ-033 rst SHALL override any state, including HALTED and mid-stall, in one cycle.
REQ-034 First request SHALL issue the cycle after rst deasserts.

Structure
REQ-035 Shared package: FSM state encoding, opcode constants (beq 4, j 2, halt 6'h3f), NOP word 32'h0, RESET_PC default.
REQ-036 One sub-module: pc_next_calc (combinational target mux of REQ-024..026).

Verification
REQ-037 Reset, imem_ready=1 always, rdata=address -> instruction 0,4,8 on consecutive cycles, inst_valid=1 from 2nd post-reset cycle.
REQ-038 jump=1, jump_immediate=26'h40, pc_out=32'h1000_0010 -> next imem_addr=32'h1000_0100, one bubble (inst_valid=0).
REQ-039 branch_taken=1, branch_offset=16'hFFFE, pc_out=32'h20 -> next imem_addr=32'h1C.
REQ-040 stall=1 for 3 cycles with jump=1 held -> imem_req=0, outputs frozen; redirect taken on first stall=0 cycle.
REQ-041 halt=1 -> halted=1, imem_req=0 for 10+ cycles; rst -> imem_addr=RESET_PC next cycle.
REQ-042 imem_ready=0 for 4 cycles -> imem_addr constant, inst_valid unchanged; PC 32'hFFFF_FFFC fetch -> next imem_addr=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// opcode constants, NOP word, reset PC default and offset helper.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALLED = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  OPC_BEQ          = 6'd4;
    localparam logic [5:0]  OPC_J            = 6'd2;
    localparam logic [5:0]  OPC_HALT         = 6'h3f;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word offset to byte displacement: sign-extend and scale by 4.
    function automatic logic [31:0] word_disp(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: halt > jump > taken branch > sequential.
// Purely combinational; the caller decides when the result is used.
module pc_next_calc
    import inst_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_en,
    input  logic        i_halt,
    input  logic        i_jump,
    input  logic [25:0] i_jump_immediate,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_offset,
    output logic [31:0] o_next_pc,
    output logic        o_redirect,
    output logic        o_halt
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    // Targets are relative to the presented instruction (pc_plus4), not the fetch PC.
    assign w_seq_pc        = i_pc + 32'd4;
    assign w_jump_target   = {i_pc_plus4[31:28], i_jump_immediate, 2'b00};
    assign w_branch_target = i_pc_plus4 + word_disp(i_branch_offset);

    // Priority mux over the redirect sources.
    always_comb begin
        o_next_pc  = w_seq_pc;
        o_redirect = 1'b0;
        o_halt     = 1'b0;
        if (i_en) begin
            if (i_halt) begin
                o_halt    = 1'b1;
                o_next_pc = i_pc;
            end else if (i_jump) begin
                o_redirect = 1'b1;
                o_next_pc  = w_jump_target;
            end else if (i_branch_taken) begin
                o_redirect = 1'b1;
                o_next_pc  = w_branch_target;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word fetches, registers the returned
// instruction for decode, and applies halt/jump/branch redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_immediate,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        halt,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    // Force word alignment so imem_addr can never be misaligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_instruction;
    logic         r_inst_valid;
    logic [31:0]  r_pc_out;
    logic         w_imem_req;
    logic         w_accept;
    logic         w_redirect_en;
    logic         w_redirect;
    logic         w_halt;
    logic [31:0]  w_next_pc;

    // Redirects only apply to a live instruction that decode is consuming.
    assign w_redirect_en = r_inst_valid && !stall && (r_state != HALTED);

    pc_next_calc u_pc_next_calc (
        .i_pc             (r_pc),
        .i_pc_plus4       (pc_plus4),
        .i_en             (w_redirect_en),
        .i_halt           (halt),
        .i_jump           (jump),
        .i_jump_immediate (jump_immediate),
        .i_branch_taken   (branch_taken),
        .i_branch_offset  (branch_offset),
        .o_next_pc        (w_next_pc),
        .o_redirect       (w_redirect),
        .o_halt           (w_halt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_next;
    end

    // Next state, request strobe and accept decision.
    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            FETCH: begin
                if (stall) begin
                    w_state_next = STALLED;
                end else begin
                    w_imem_req = 1'b1;
                    if (w_halt)
                        w_state_next = HALTED;
                    else if (!w_redirect && imem_ready)
                        w_accept = 1'b1;
                end
            end
            STALLED: begin
                if (!stall)
                    w_state_next = w_halt ? HALTED : FETCH;
            end
            HALTED: w_state_next = HALTED;
            default: w_state_next = FETCH;
        endcase
        if (rst) w_imem_req = 1'b0;
    end

    // PC and instruction registers; a redirect drops whatever memory returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC_ALIGNED;
            r_instruction <= NOP_WORD;
            r_inst_valid  <= 1'b0;
            r_pc_out      <= RESET_PC_ALIGNED;
        end else if (w_redirect) begin
            r_pc         <= w_next_pc;
            r_inst_valid <= 1'b0;
        end else if (w_halt) begin
            r_inst_valid <= 1'b0;
        end else if (w_accept) begin
            r_instruction <= imem_rdata;
            r_pc_out      <= r_pc;
            r_inst_valid  <= 1'b1;
            r_pc          <= w_next_pc;
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_pc;
    assign instruction = r_instruction;
    assign inst_valid  = r_inst_valid;
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_out + 32'd4;
    assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a table of per-cycle input/expected-output rows run
// through a scoreboard queue, plus a short sequence on a second instance
// with a high reset PC for the jump-target case.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, imem_ready, stall, jump, branch_taken, halt;
    logic [25:0] jump_immediate;
    logic [15:0] branch_offset;

    logic        req0, iv0, halted0;
    logic [31:0] addr0, rdata0, instr0, pcout0, pcp40;
    logic        req1, iv1, halted1;
    logic [31:0] addr1, rdata1, instr1, pcout1, pcp41;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Memory model: returned word equals its address.
    assign rdata0 = addr0;
    assign rdata1 = addr1;

    inst_fetch u_dut (
        .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0),
        .imem_ready(imem_ready), .imem_rdata(rdata0), .stall(stall),
        .jump(jump), .jump_immediate(jump_immediate),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .halt(halt), .instruction(instr0), .inst_valid(iv0),
        .pc_out(pcout0), .pc_plus4(pcp40), .halted(halted0)
    );

    inst_fetch #(.RESET_PC(32'h1000_0000)) u_dut_hi (
        .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1),
        .imem_ready(imem_ready), .imem_rdata(rdata1), .stall(stall),
        .jump(jump), .jump_immediate(jump_immediate),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .halt(halt), .instruction(instr1), .inst_valid(iv1),
        .pc_out(pcout1), .pc_plus4(pcp41), .halted(halted1)
    );

    typedef struct {
        logic        rst, rdy, stall, jump;
        logic [25:0] jimm;
        logic        br;
        logic [15:0] boff;
        logic        halt;
        logic        chk;
        logic        req;
        logic [31:0] addr, instr;
        logic        iv;
        logic [31:0] pcout;
        logic        halted;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic void add(input logic [31:0] a_rst, a_rdy, a_stall, a_jump,
                                a_jimm, a_br, a_boff, a_halt,
                                e_req, e_addr, e_instr, e_iv, e_pcout, e_halted);
        vec_t v;
        v.rst = a_rst[0];   v.rdy = a_rdy[0];   v.stall = a_stall[0];
        v.jump = a_jump[0]; v.jimm = a_jimm[25:0]; v.br = a_br[0];
        v.boff = a_boff[15:0]; v.halt = a_halt[0]; v.chk = 1'b1;
        v.req = e_req[0];   v.addr = e_addr;    v.instr = e_instr;
        v.iv = e_iv[0];     v.pcout = e_pcout;  v.halted = e_halted[0];
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    task automatic drive(input logic a_rst, a_rdy, a_stall, a_jump,
                         input logic [25:0] a_jimm, input logic a_br,
                         input logic [15:0] a_boff, input logic a_halt);
        @(negedge clk);
        rst = a_rst; imem_ready = a_rdy; stall = a_stall; jump = a_jump;
        jump_immediate = a_jimm; branch_taken = a_br; branch_offset = a_boff;
        halt = a_halt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t e;
        rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; jump = 1'b0;
        jump_immediate = '0; branch_taken = 1'b0; branch_offset = '0; halt = 1'b0;

        // rst rdy stl jmp jimm br boff halt | req addr instr iv pcout halted
        add(1,1,0,0,0,0,0,0,      0,0,0,0,0,0);
        tbl[0].chk = 1'b0;
        add(1,1,0,0,0,0,0,0,      0,0,0,0,0,0);
        add(0,1,0,0,0,0,0,0,      1,0,0,0,0,0);
        add(0,1,0,0,0,0,0,0,      1,4,0,1,0,0);
        add(0,1,0,0,0,0,0,0,      1,8,4,1,4,0);
        add(0,1,0,1,8,0,0,0,      1,'hC,8,1,8,0);
        add(0,1,0,1,8,0,0,0,      1,'h20,8,0,8,0);
        add(0,1,0,0,0,1,'hFFFE,0, 1,'h24,'h20,1,'h20,0);
        add(0,1,0,0,0,0,0,0,      1,'h1C,'h20,0,'h20,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,0,0,0,0,  1,'h20,'h1C,1,'h1C,0);
        add(0,1,0,0,0,0,0,0,      1,'h20,'h1C,1,'h1C,0);
        add(0,1,0,1,4,1,'h10,0,   1,'h24,'h20,1,'h20,0);
        add(0,1,0,0,0,0,0,0,      1,'h10,'h20,0,'h20,0);
        for (int i = 0; i < 3; i++)
            add(0,1,1,1,'h30,0,0,0, 0,'h14,'h10,1,'h10,0);
        add(0,1,0,1,'h30,0,0,0,   0,'h14,'h10,1,'h10,0);
        add(0,1,0,0,0,0,0,0,      1,'hC0,'h10,0,'h10,0);
        add(0,1,0,0,0,1,'hFFCE,0, 1,'hC4,'hC0,1,'hC0,0);
        add(0,1,0,0,0,0,0,0,      1,'hFFFF_FFFC,'hC0,0,'hC0,0);
        add(0,1,0,0,0,0,0,0,      1,0,'hFFFF_FFFC,1,'hFFFF_FFFC,0);
        add(0,1,0,1,'h30,0,0,1,   1,4,0,1,0,0);
        for (int i = 0; i < 10; i++)
            add(0,1,0,0,0,0,0,0,  0,4,0,0,0,1);
        add(1,1,0,0,0,0,0,0,      0,4,0,0,0,1);
        add(0,1,0,0,0,0,0,0,      1,0,0,0,0,0);
        add(0,1,1,0,0,0,0,0,      0,4,0,1,0,0);
        add(1,1,1,0,0,0,0,0,      0,4,0,1,0,0);
        add(0,1,0,0,0,0,0,0,      1,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].stall, tbl[i].jump,
                  tbl[i].jimm, tbl[i].br, tbl[i].boff, tbl[i].halt);
            sb.push_back(tbl[i]);
            #2;
            e = sb.pop_front();
            if (e.chk) begin
                chk("imem_req",    i, {31'b0, req0},    {31'b0, e.req});
                chk("imem_addr",   i, addr0,            e.addr);
                chk("instruction", i, instr0,           e.instr);
                chk("inst_valid",  i, {31'b0, iv0},     {31'b0, e.iv});
                chk("pc_out",      i, pcout0,           e.pcout);
                chk("pc_plus4",    i, pcp40,            e.pcout + 32'd4);
                chk("halted",      i, {31'b0, halted0}, {31'b0, e.halted});
            end
        end

        // High reset PC instance: walk to 0x1000_0010 then jump.
        drive(1,0,0,0,0,0,0,0);
        drive(1,0,0,0,0,0,0,0);
        drive(0,1,0,0,0,0,0,0);
        #2 chk("hi_reset_addr", 100, addr1, 32'h1000_0000);
        for (int k = 0; k < 4; k++) drive(0,1,0,0,0,0,0,0);
        drive(0,1,0,1,26'h40,0,0,0);
        #2;
        chk("hi_pc_out",  101, pcout1, 32'h1000_0010);
        chk("hi_valid",   101, {31'b0, iv1}, 32'd1);
        drive(0,1,0,0,0,0,0,0);
        #2;
        chk("hi_jump_addr", 102, addr1, 32'h1000_0100);
        chk("hi_bubble",    102, {31'b0, iv1}, 32'd0);
        drive(0,1,0,0,0,0,0,0);
        #2;
        chk("hi_instr",  103, instr1, 32'h1000_0100);
        chk("hi_pc_out2", 103, pcout1, 32'h1000_0100);
        chk("hi_valid2", 103, {31'b0, iv1}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
